// File: rtl/wishbone_slave_ram_pkg.sv
// Shared encodings and constants for the Wishbone slave RAM.
// State encoding of the responder FSM plus the common word/enable constants.
package wishbone_slave_ram_pkg;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'b00,
        WB_S_WAIT = 2'b01,
        WB_S_ACK  = 2'b10
    } wb_state_t;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        ResetEnable  = 1'b1;

    localparam int WaitCountWidth = 4;

endpackage

// File: rtl/wishbone_slave_ram_array.sv
// Word-wide RAM built from four byte-lane arrays; synchronous write with
// per-lane enables, synchronous registered read. Contents are never reset.
module wishbone_slave_ram_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [3:0]            i_sel,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rd;

        always_ff @(posedge clock) begin
            if (i_wr_en && i_sel[g]) begin
                r_mem[i_addr] <= i_wdata[8*g +: 8];
            end
            if (i_rd_en) begin
                r_rd <= r_mem[i_addr];
            end
        end

        assign o_rdata[8*g +: 8] = r_rd;
    end

endmodule

// File: rtl/wishbone_slave_ram.sv
// Wishbone classic responder in front of an on-chip RAM with base-address
// decode and programmable wait states. Define WB_SLAVE_ERR_EN to terminate
// out-of-range accesses with err instead of ack.
module wishbone_slave_ram
    import wishbone_slave_ram_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wishbone_address_input,
    input  logic [31:0] wishbone_data_input,
    input  logic        wishbone_write_enable_input,
    input  logic [3:0]  wishbone_sel_input,
    input  logic        wishbone_stb_input,
    input  logic        wishbone_cyc_input,
    output logic [31:0] wishbone_data_output,
    output logic        wishbone_ack_output,
    output logic        wishbone_err_output,
    output logic [1:0]  debug_state_output
);

    localparam logic [WaitCountWidth-1:0] LP_WAIT_LOAD =
        (WAIT_STATES > 0) ? WaitCountWidth'(WAIT_STATES - 1) : '0;

    wb_state_t r_state;
    wb_state_t w_next_state;

    logic [WaitCountWidth-1:0] r_count;
    logic [ADDR_WIDTH-1:0]     r_word;
    logic [31:0]               r_wdata;
    logic                      r_we;
    logic [3:0]                r_sel;
    logic                      r_in_range;
    logic                      r_ack;
    logic                      r_err;

    logic                      w_req;
    logic                      w_in_range;
    logic                      w_capture;
    logic                      w_enter_ack;
    logic                      w_ack_next;
    logic                      w_err_next;
    logic                      w_mem_wr;
    logic                      w_mem_rd;
    logic [ADDR_WIDTH-1:0]     w_xfer_word;
    logic [31:0]               w_xfer_wdata;
    logic                      w_xfer_we;
    logic [3:0]                w_xfer_sel;
    logic                      w_xfer_in_range;
    logic [31:0]               w_rdata;
    logic                      w_unused;

    assign w_req      = wishbone_cyc_input & wishbone_stb_input;
    assign w_in_range = (wishbone_address_input[31:ADDR_WIDTH+2] ==
                         BASE_ADDRESS[31:ADDR_WIDTH+2]);
    assign w_unused   = ^wishbone_address_input[1:0];

    // With zero wait states the memory access happens on the sampling edge,
    // so the live bus values are used instead of the latched copies.
    assign w_xfer_word     = (r_state == WB_S_IDLE) ? wishbone_address_input[ADDR_WIDTH+1:2] : r_word;
    assign w_xfer_wdata    = (r_state == WB_S_IDLE) ? wishbone_data_input : r_wdata;
    assign w_xfer_we       = (r_state == WB_S_IDLE) ? wishbone_write_enable_input : r_we;
    assign w_xfer_sel      = (r_state == WB_S_IDLE) ? wishbone_sel_input : r_sel;
    assign w_xfer_in_range = (r_state == WB_S_IDLE) ? w_in_range : r_in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset == ResetEnable) begin
            r_state <= WB_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WB_S_IDLE: begin
                if (w_req) begin
                    w_next_state = (WAIT_STATES == 0) ? WB_S_ACK : WB_S_WAIT;
                end
            end
            WB_S_WAIT: begin
                if (!wishbone_cyc_input) begin
                    w_next_state = WB_S_IDLE;
                end else if (r_count == '0) begin
                    w_next_state = WB_S_ACK;
                end
            end
            WB_S_ACK: w_next_state = WB_S_IDLE;
            default:  w_next_state = WB_S_IDLE;
        endcase
    end

    always_comb begin
        w_capture   = (r_state == WB_S_IDLE) && w_req;
        w_enter_ack = (w_next_state == WB_S_ACK);
        w_mem_wr    = w_enter_ack && w_xfer_in_range && (w_xfer_we == WriteEnable);
        w_mem_rd    = w_enter_ack && w_xfer_in_range && (w_xfer_we == WriteDisable);
`ifdef WB_SLAVE_ERR_EN
        w_ack_next  = w_enter_ack && w_xfer_in_range;
        w_err_next  = w_enter_ack && !w_xfer_in_range;
`else
        w_ack_next  = w_enter_ack;
        w_err_next  = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset == ResetEnable) begin
            r_count    <= '0;
            r_word     <= '0;
            r_wdata    <= ZeroWord;
            r_we       <= WriteDisable;
            r_sel      <= '0;
            r_in_range <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_count    <= LP_WAIT_LOAD;
                r_word     <= wishbone_address_input[ADDR_WIDTH+1:2];
                r_wdata    <= wishbone_data_input;
                r_we       <= wishbone_write_enable_input;
                r_sel      <= wishbone_sel_input;
                r_in_range <= w_in_range;
            end else if ((r_state == WB_S_WAIT) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
            r_ack <= w_ack_next;
            r_err <= w_err_next;
        end
    end

    wishbone_slave_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clock   (clock),
        .i_wr_en (w_mem_wr),
        .i_rd_en (w_mem_rd),
        .i_sel   (w_xfer_sel),
        .i_addr  (w_xfer_word),
        .i_wdata (w_xfer_wdata),
        .o_rdata (w_rdata)
    );

    // Read data is only presented during an in-range read ack.
    assign wishbone_data_output = (r_ack && r_in_range && (r_we == WriteDisable)) ? w_rdata : ZeroWord;
    assign wishbone_ack_output  = r_ack;
    assign wishbone_err_output  = r_err;
    assign debug_state_output   = r_state;

endmodule
